instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DB_CYCLES, default 16, SHALL set the consecutive stable cycles needed to accept a button level change; legal range 1..65535.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: one clock; reset is asynchronous and active-high.
REQ-004 Port btn_raw  input  1  SHALL be the raw, asynchronous, bouncing push-button level; 1 means pressed.
REQ-005 Port data_in  input  8  SHALL be the switch byte, sampled only on an accepted press.
REQ-006 Port clr  input  1  SHALL be a synchronous abort that returns the loader to S_HI.
REQ-007 Port opcode  output  4  SHALL be the published opcode feeding the CPU core.
REQ-008 Port instr  output  12  SHALL be the published operand field feeding the CPU core.
REQ-009 Port inst_done  output  1  SHALL be a one-cycle pulse marking new opcode/instr.
REQ-010 Port btn_edge  output  1  SHALL be a one-cycle pulse for each accepted press.
REQ-011 Port load_state  output  2  SHALL expose the FSM state for LEDs: 00 S_HI, 01 S_LO, 10 S_EXEC.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Debounce: a counter SHALL increment while the synchronized level differs from the debounced level, and SHALL clear on any cycle where they match.
REQ-014 The debounced level SHALL flip, and the counter SHALL clear, on the edge where the counter reaches DB_CYCLES-1 while the levels still differ.
REQ-015 Glitches shorter than DB_CYCLES cycles SHALL NOT change the debounced level.
REQ-016 btn_edge SHALL be a registered output, high for exactly one cycle in the cycle after the debounced level goes 0->1.
REQ-017 A debounced release (1->0) SHALL NOT produce btn_edge.
REQ-018 Latency from btn_raw stably high to btn_edge high SHALL be 2+DB_CYCLES+1 clock edges, ±1 for input sampling phase.
REQ-019 FSM states SHALL be S_HI, S_LO and S_EXEC.
REQ-020 In S_HI with btn_edge=1: data_in SHALL be captured into a staging byte hi_q, and the state SHALL become S_LO.
REQ-021 In S_LO with btn_edge=1: opcode SHALL be loaded with hi_q[7:4], instr with {hi_q[3:0], data_in}, inst_done set to 1, and the state SHALL become S_EXEC, all on the same edge.
REQ-022 In S_EXEC with btn_edge=1: the state SHALL return to S_HI; no capture occurs and the outputs are unchanged.
REQ-023 inst_done SHALL be high for exactly one cycle and SHALL be 0 in every other cycle.
REQ-024 opcode and instr SHALL change only together with inst_done, and SHALL hold their values between loads.
REQ-025 clr=1 SHALL force S_HI on the next edge and discard hi_q.
REQ-026 clr=1 SHALL NOT alter opcode, instr or the debouncer, and SHALL suppress any capture or inst_done in that cycle.
REQ-027 If clr and btn_edge are high in the same cycle, clr SHALL win the state update; btn_edge SHALL still be output.
REQ-028 btn_edge SHALL pulse in every state, so the core observes every press.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, clear the synchronizer, debounced level, counter, hi_q, opcode, instr, inst_done and btn_edge to 0, and set the state to S_HI.
REQ-030 rst asserted mid-load, in S_LO, SHALL discard the staged byte; the next press after release SHALL be treated as the high byte.
REQ-031 The first press after rst deassertion SHALL require the full debounce period; a button held through reset SHALL yield btn_edge only after DB_CYCLES stable cycles past reset.

Verification
REQ-032 DB_CYCLES=4, clean press, data_in=8'hA5 -> btn_edge single pulse 7±1 edges after the press; load_state goes 00->01; opcode and instr unchanged.
REQ-033 Two presses with data_in 8'h3C then 8'h7E -> one inst_done pulse; opcode=4'h3, instr=12'hC7E; load_state=10.
REQ-034 Bounce pattern of 1,0,1,0 pulses each of 3 cycles with DB_CYCLES=4, then a stable press -> exactly one btn_edge.
REQ-035 Third press in S_EXEC -> btn_edge pulses; load_state=00; opcode and instr still 4'h3 and 12'hC7E; no inst_done.
REQ-036 In S_LO, assert clr for one cycle, then make two presses with 8'h91 and 8'h02 -> opcode=4'h9, instr=12'h102.
REQ-037 Assert rst asynchronously between clock edges during S_LO -> all outputs are 0 before the next edge, and load_state=00.

Source files
------------

// File: rtl/instr_loader.sv
// Push-button instruction loader: synchronizes and debounces a button, then assembles
// two switch bytes into a 4-bit opcode and 12-bit operand for the CPU core.
module instr_loader #(
    parameter int DB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic [7:0]  data_in,
    input  logic        clr,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        btn_edge,
    output logic [1:0]  load_state
);

    typedef enum logic [1:0] {
        S_HI   = 2'b00,
        S_LO   = 2'b01,
        S_EXEC = 2'b10
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic        r_sync1, r_sync2;
    logic        r_db, r_db_d;
    logic [15:0] r_cnt;
    logic        r_btn_edge;
    state_t      r_state, w_state_nxt;
    logic        w_cap_hi, w_load;
    logic [7:0]  r_hi_q;
    logic [3:0]  r_opcode;
    logic [11:0] r_instr;
    logic        r_inst_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_db) begin
            if (r_cnt == DB_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_d     <= 1'b0;
            r_btn_edge <= 1'b0;
        end else begin
            r_db_d     <= r_db;
            r_btn_edge <= r_db & ~r_db_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_HI;
        else     r_state <= w_state_nxt;
    end

    // clr overrides any press seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_hi    = 1'b0;
        w_load      = 1'b0;
        if (clr) begin
            w_state_nxt = S_HI;
        end else if (r_btn_edge) begin
            case (r_state)
                S_HI: begin
                    w_cap_hi    = 1'b1;
                    w_state_nxt = S_LO;
                end
                S_LO: begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EXEC;
                end
                S_EXEC:  w_state_nxt = S_HI;
                default: w_state_nxt = S_HI;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_q      <= '0;
            r_opcode    <= '0;
            r_instr     <= '0;
            r_inst_done <= 1'b0;
        end else begin
            r_inst_done <= w_load;
            if (clr)
                r_hi_q <= '0;
            else if (w_cap_hi)
                r_hi_q <= data_in;
            if (w_load) begin
                r_opcode <= r_hi_q[7:4];
                r_instr  <= {r_hi_q[3:0], data_in};
            end
        end
    end

    assign opcode     = r_opcode;
    assign instr      = r_instr;
    assign inst_done  = r_inst_done;
    assign btn_edge   = r_btn_edge;
    assign load_state = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with DB_CYCLES=4: presses, bounce, clr and async reset.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_raw;
    logic [7:0]  data_in;
    logic        clr;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic [1:0]  load_state;

    int total = 0;
    int bad   = 0;
    int g_lat, g_edges, g_dones;

    instr_loader #(.DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .data_in    (data_in),
        .clr        (clr),
        .opcode     (opcode),
        .instr      (instr),
        .inst_done  (inst_done),
        .btn_edge   (btn_edge),
        .load_state (load_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (btn_edge)  g_edges++;
        if (inst_done) g_dones++;
    endtask

    // Hold the button 20 cycles then release for 12; optionally raise clr in the btn_edge cycle.
    task automatic press(input logic [7:0] d, input bit clr_on_edge);
        g_lat = -1; g_edges = 0; g_dones = 0;
        data_in = d;
        btn_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (clr) clr = 1'b0;
            if (btn_edge && g_lat < 0) begin
                g_lat = i;
                if (clr_on_edge) clr = 1'b1;
            end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_opcode"}, 32'(opcode), 32'h0);
        check({tag, "_instr"},  32'(instr), 32'h0);
        check({tag, "_done"},   32'(inst_done), 32'h0);
        check({tag, "_edge"},   32'(btn_edge), 32'h0);
        check({tag, "_state"},  32'(load_state), 32'h0);
    endtask

    initial begin
        int b_edges, b_dones;
        rst = 1'b1; btn_raw = 1'b0; data_in = 8'h00; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Clean press of the high byte
        press(8'hA5, 1'b0);
        check($sformatf("p1_latency_%0d", g_lat), 32'((g_lat >= 6 && g_lat <= 8) ? 1 : 0), 32'd1);
        check("p1_edges", 32'(g_edges), 32'd1);
        check("p1_dones", 32'(g_dones), 32'd0);
        check("p1_state", 32'(load_state), 32'h1);
        check("p1_opcode", 32'(opcode), 32'h0);
        check("p1_instr", 32'(instr), 32'h0);

        clr = 1'b1; tick(); clr = 1'b0; tick();
        check("clr1_state", 32'(load_state), 32'h0);

        press(8'h3C, 1'b0);
        check("p2_state", 32'(load_state), 32'h1);
        press(8'h7E, 1'b0);
        check("p3_dones", 32'(g_dones), 32'd1);
        check("p3_opcode", 32'(opcode), 32'h3);
        check("p3_instr", 32'(instr), 32'hC7E);
        check("p3_state", 32'(load_state), 32'h2);

        // Bounce 1,0,1,0 of 3 cycles each, then a stable press while in S_EXEC
        g_edges = 0; g_dones = 0;
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0);
            repeat (3) tick();
        end
        b_edges = g_edges; b_dones = g_dones;
        press(8'hFF, 1'b0);
        check("bounce_edges", 32'(b_edges + g_edges), 32'd1);
        check("exec_dones", 32'(b_dones + g_dones), 32'd0);
        check("exec_state", 32'(load_state), 32'h0);
        check("exec_opcode", 32'(opcode), 32'h3);
        check("exec_instr", 32'(instr), 32'hC7E);

        // Abort mid-load, then a fresh two-byte load
        press(8'h55, 1'b0);
        check("p55_state", 32'(load_state), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        check("clr2_state", 32'(load_state), 32'h0);
        press(8'h91, 1'b0);
        press(8'h02, 1'b0);
        check("p02_dones", 32'(g_dones), 32'd1);
        check("p02_opcode", 32'(opcode), 32'h9);
        check("p02_instr", 32'(instr), 32'h102);
        check("p02_state", 32'(load_state), 32'h2);

        // clr coinciding with btn_edge in S_LO
        press(8'h66, 1'b0);
        check("p66_state", 32'(load_state), 32'h0);
        press(8'h77, 1'b0);
        press(8'h88, 1'b1);
        check("clredge_edges", 32'(g_edges), 32'd1);
        check("clredge_dones", 32'(g_dones), 32'd0);
        check("clredge_state", 32'(load_state), 32'h0);
        check("clredge_opcode", 32'(opcode), 32'h9);
        check("clredge_instr", 32'(instr), 32'h102);

        // Asynchronous reset between edges while in S_LO
        press(8'h12, 1'b0);
        check("p12_state", 32'(load_state), 32'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #2;
        check_all_zero("arst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) tick();
        press(8'h34, 1'b0);
        check("p34_state", 32'(load_state), 32'h1);
        press(8'h56, 1'b0);
        check("p56_opcode", 32'(opcode), 32'h3);
        check("p56_instr", 32'(instr), 32'h456);

        // Button held through reset needs the full debounce after release
        btn_raw = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        g_lat = -1; g_edges = 0; g_dones = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (btn_edge && g_lat < 0) g_lat = i;
        end
        btn_raw = 1'b0;
        repeat (12) tick();
        check($sformatf("held_latency_%0d", g_lat), 32'((g_lat >= 6 && g_lat <= 8) ? 1 : 0), 32'd1);
        check("held_edges", 32'(g_edges), 32'd1);
        check("held_state", 32'(load_state), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
